// File: rtl/io_scan_pkg.sv
// Shared types, defaults and sizing helpers for the IO scan controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package io_scan_pkg;

  // Default pad counts
  localparam int IO_SCAN_N_IN  = 14;
  localparam int IO_SCAN_N_OUT = 7;

  // FSM state encoding (binary)
  typedef logic [1:0] scan_state_t;
  localparam scan_state_t ST_IDLE    = 2'd0;
  localparam scan_state_t ST_CAPTURE = 2'd1;
  localparam scan_state_t ST_SHIFT   = 2'd2;
  localparam scan_state_t ST_UPDATE  = 2'd3;

  // Shift length: long enough to drain every input pad and fill every output pad
  function automatic int scan_len(input int n_in, input int n_out);
    return (n_in > n_out) ? n_in : n_out;
  endfunction

  // Bit-counter width able to hold 0..l
  function automatic int cnt_width(input int l);
    return $clog2(l + 1);
  endfunction

endpackage

// File: rtl/io_scan_sync.sv
// Two-flop synchronizer for the raw input-pad bus (used when IO_SCAN_SYNC_EN is defined).
// Latency: 2 cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
module io_scan_sync #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage resync, both stages cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_scan_ctrl.sv
// IO scan controller: captures input pads, shifts them out serially while shifting output-pad data in, then updates pad_out.
// Latency: start to done = L+2 cycles with scan_en high (CAPTURE 1, SHIFT L, UPDATE 1); optional IO_SCAN_SYNC_EN adds 2 cycles on pad_in only.
// Backpressure: scan_en low stalls SHIFT with all state held; start while busy is dropped, not queued.
module io_scan_ctrl
  import io_scan_pkg::*;
#(
  parameter int N_IN  = IO_SCAN_N_IN,
  parameter int N_OUT = IO_SCAN_N_OUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             scan_en,
  input  logic             scan_in,
  input  logic [N_IN-1:0]  pad_in,
  output logic             scan_out,
  output logic [N_OUT-1:0] pad_out,
  output logic             busy,
  output logic             done
);

  localparam int L  = scan_len(N_IN, N_OUT);
  localparam int CW = cnt_width(L);
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  scan_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_IN-1:0]  in_sr_q, in_sr_d;
  logic [N_OUT-1:0] out_sr_q, out_sr_d;
  logic [N_OUT-1:0] pad_out_q, pad_out_d;
  logic [N_IN-1:0]  pad_cap;

`ifdef IO_SCAN_SYNC_EN
  io_scan_sync #(
    .W (N_IN)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pad_in),
    .q_o   (pad_cap)
  );
`else
  assign pad_cap = pad_in;
`endif

  // Next-state and datapath: capture, shift (gated by scan_en), update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_sr_d   = in_sr_q;
    out_sr_d  = out_sr_q;
    pad_out_d = pad_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        in_sr_d = pad_cap;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (scan_en) begin
          in_sr_d             = in_sr_q >> 1;
          out_sr_d            = out_sr_q >> 1;
          out_sr_d[N_OUT-1]   = scan_in;
          cnt_d               = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pad_out_d = out_sr_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction and clears pad_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      in_sr_q   <= '0;
      out_sr_q  <= '0;
      pad_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_sr_q   <= in_sr_d;
      out_sr_q  <= out_sr_d;
      pad_out_q <= pad_out_d;
    end
  end

  // scan_out shows the low shift bit only while shifting; it holds naturally during a stall
  assign scan_out = (state_q == ST_SHIFT) & in_sr_q[0];
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_UPDATE);
  assign pad_out  = pad_out_q;

endmodule
